// File: rtl/sd_cmd_response_rx_if.sv
// Bundle of the CMD-line receiver's control, status and register-bank buses.
//
// Handshake: start is a one-cycle request that is accepted only while busy=0.
// busy rises the cycle after acceptance and falls in the cycle done pulses.
// done is a one-cycle completion pulse. Status flags are valid from done and
// hold until the next accepted start. Load enables pulse only together with done.
interface sd_cmd_response_rx_if;
    logic         cmd_in;
    logic         start;
    logic [2:0]   resp_type;
    logic [5:0]   exp_index;
    logic         r2_is_csd;
    logic         busy;
    logic         done;
    logic         timeout_err;
    logic         crc_err;
    logic         index_err;
    logic         frame_err;
    logic         cid_en;
    logic         csd_en;
    logic         ocr_en;
    logic         rca_en;
    logic         stat_en;
    logic [127:0] r2_data;
    logic [31:0]  ocr_data;
    logic [15:0]  rca_data;
    logic [63:0]  stat_data;
    logic [1:0]   fsm_state;

    modport master (
        output cmd_in, start, resp_type, exp_index, r2_is_csd,
        input  busy, done, timeout_err, crc_err, index_err, frame_err,
        input  cid_en, csd_en, ocr_en, rca_en, stat_en,
        input  r2_data, ocr_data, rca_data, stat_data, fsm_state
    );

    modport slave (
        input  cmd_in, start, resp_type, exp_index, r2_is_csd,
        output busy, done, timeout_err, crc_err, index_err, frame_err,
        output cid_en, csd_en, ocr_en, rca_en, stat_en,
        output r2_data, ocr_data, rca_data, stat_data, fsm_state
    );
endinterface

// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver: hunts for the start bit, shifts in a 48- or
// 136-bit frame, checks framing / CRC7 / index and drives register-bank loads.
module sd_cmd_response_rx #(
    parameter int NCR_MAX = 64,
    parameter int CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset,
    sd_cmd_response_rx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECV       = 2'd2,
        CHECK      = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       typ;
    logic [5:0]       idx_exp;
    logic             csd_sel;
    logic [CNT_W-1:0] cnt;
    logic [135:0]     frame;
    logic [6:0]       crc;

    logic             type_ok;
    logic             is_r2;
    logic             is_r3;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W-1:0] frame_len;
    logic             crc_on;
    logic [6:0]       crc_next;
    logic             start_bit;
    logic             trans_bit;
    logic [5:0]       hdr_idx;
    logic [6:0]       crc_field;
    logic [31:0]      content;
    logic             e_frame;
    logic             e_crc;
    logic             e_index;
    logic             ok;

    assign type_ok   = (bus.resp_type == 3'd1) || (bus.resp_type == 3'd2) ||
                       (bus.resp_type == 3'd3) || (bus.resp_type == 3'd6) ||
                       (bus.resp_type == 3'd7);
    assign is_r2     = (typ == 3'd2);
    assign is_r3     = (typ == 3'd3);
    assign nxt_cnt   = cnt + 1'b1;
    assign frame_len = is_r2 ? CNT_W'(136) : CNT_W'(48);

    // nxt_cnt is the 1-based number of the bit being received. R2 CRC covers
    // the payload only (bits 9..128); short frames cover bits 1..40.
    assign crc_on    = is_r2 ? ((nxt_cnt >= CNT_W'(9)) && (nxt_cnt <= CNT_W'(128)))
                             : (nxt_cnt <= CNT_W'(40));
    assign crc_next  = {crc[5:0], 1'b0} ^ ({7{bus.cmd_in ^ crc[6]}} & 7'h09);

    assign start_bit = is_r2 ? frame[135] : frame[47];
    assign trans_bit = is_r2 ? frame[134] : frame[46];
    assign hdr_idx   = is_r2 ? frame[133:128] : frame[45:40];
    assign crc_field = frame[7:1];
    assign content   = frame[39:8];

    assign e_frame   = start_bit | trans_bit | ~frame[0] | (is_r3 && (crc_field != 7'h7F));
    assign e_crc     = !is_r3 && (crc != crc_field);
    assign e_index   = (is_r2 || is_r3) ? (hdr_idx != 6'h3F) : (hdr_idx != idx_exp);
    assign ok        = !(e_frame || e_crc || e_index);

    assign bus.fsm_state = state;

    // Receiver FSM with registered status, enables and data buses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            typ             <= 3'd0;
            idx_exp         <= 6'd0;
            csd_sel         <= 1'b0;
            cnt             <= '0;
            frame           <= '0;
            crc             <= 7'd0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.crc_err     <= 1'b0;
            bus.index_err   <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.cid_en      <= 1'b0;
            bus.csd_en      <= 1'b0;
            bus.ocr_en      <= 1'b0;
            bus.rca_en      <= 1'b0;
            bus.stat_en     <= 1'b0;
            bus.r2_data     <= '0;
            bus.ocr_data    <= '0;
            bus.rca_data    <= '0;
            bus.stat_data   <= '0;
        end else begin
            bus.done   <= 1'b0;
            bus.cid_en <= 1'b0;
            bus.csd_en <= 1'b0;
            bus.ocr_en <= 1'b0;
            bus.rca_en <= 1'b0;
            bus.stat_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.timeout_err <= 1'b0;
                        bus.crc_err     <= 1'b0;
                        bus.index_err   <= 1'b0;
                        bus.frame_err   <= 1'b0;
                        if (!type_ok) begin
                            bus.done <= 1'b1;
                        end else begin
                            typ      <= bus.resp_type;
                            idx_exp  <= bus.exp_index;
                            csd_sel  <= bus.r2_is_csd;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= WAIT_START;
                        end
                    end
                end
                WAIT_START: begin
                    if (cnt == CNT_W'(NCR_MAX)) begin
                        bus.timeout_err <= 1'b1;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else if (!bus.cmd_in) begin
                        // The start bit is bit 1; a zero input leaves CRC at 0.
                        cnt   <= CNT_W'(1);
                        frame <= '0;
                        crc   <= 7'd0;
                        state <= RECV;
                    end else begin
                        cnt <= nxt_cnt;
                    end
                end
                RECV: begin
                    frame <= {frame[134:0], bus.cmd_in};
                    cnt   <= nxt_cnt;
                    if (crc_on) crc <= crc_next;
                    if (nxt_cnt == frame_len) state <= CHECK;
                end
                CHECK: begin
                    bus.frame_err <= e_frame;
                    bus.crc_err   <= e_crc;
                    bus.index_err <= e_index;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                    case (typ)
                        3'd1, 3'd7: begin
                            bus.stat_data <= {26'b0, hdr_idx, content};
                            bus.stat_en   <= ok;
                        end
                        3'd6: begin
                            bus.rca_data  <= content[31:16];
                            bus.stat_data <= {26'b0, hdr_idx, 16'b0, content[15:0]};
                            bus.rca_en    <= ok;
                            bus.stat_en   <= ok;
                        end
                        3'd3: begin
                            bus.ocr_data  <= content;
                            bus.stat_data <= {26'b0, 6'h3F, content};
                            bus.ocr_en    <= ok;
                            bus.stat_en   <= ok;
                        end
                        3'd2: begin
                            bus.r2_data <= {frame[127:1], 1'b1};
                            bus.csd_en  <= ok && csd_sel;
                            bus.cid_en  <= ok && !csd_sel;
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sd_cmd_response_rx.md
# sd_cmd_response_rx

Serial receiver for SD-card responses on the CMD line. After the command sender finishes a command, this block hunts for the response start bit and shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame. It checks framing, the CRC7 and the command index, then drives the load enables and data buses of the SD register bank (CID, CSD, OCR, RCA, status). It sits directly upstream of the register bank and downstream of the command transmitter.

## Interface
Parameters:
- NCR_MAX, 64, max CMD-line cycles to wait for a start bit before timeout
- CNT_W, 8, width of the wait/bit counter; must hold max(NCR_MAX, 136)

Ports:
- clk  in  1  SD clock; the CMD line is sampled on the rising edge
- reset  in  1  synchronous, active-low; all state and outputs cleared on a rising clk edge while low
- cmd_in  in  1  CMD line sample
- start  in  1  one-cycle pulse; arm the receiver; ignored unless busy=0
- resp_type  in  3  0=NONE, 1=R1, 2=R2, 3=R3, 6=R6, 7=R7; other codes are treated as NONE; sampled with start
- exp_index  in  6  expected command index for R1/R6/R7; sampled with start
- r2_is_csd  in  1  R2 payload goes to CSD (1) or CID (0); sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- timeout_err, crc_err, index_err, frame_err  out  1 each  status flags, valid from done, held until the next accepted start or reset
- cid_en, csd_en, ocr_en, rca_en, stat_en  out  1 each  one-cycle load pulses, coincident with done
- r2_data  out  128  CID/CSD value, shared by cid_in and csd_in
- ocr_data  out  32  OCR value
- rca_data  out  16  new RCA
- stat_data  out  64  [31:0] card status, [37:32] response index, [63:38] zero

## Operation
- States: IDLE, WAIT_START, RECV, CHECK.
- IDLE + start, with resp_type NONE: done pulses on the next cycle. No enables fire, flags clear, busy stays 0.
- IDLE + start, with any other resp_type: latch resp_type, exp_index and r2_is_csd; clear the flags; go to WAIT_START with the counter at 0.
- WAIT_START:
  - cmd_in=0 → RECV; this start bit counts as bit 1.
  - cmd_in=1 → counter+1.
  - Counter reaching NCR_MAX high samples → timeout_err=1, done, IDLE.
- RECV: shift cmd_in into the frame register MSB-first until frame length L is reached (L=48, or 136 for R2). The L-th bit is the end bit; the next state is CHECK.
- CRC7 uses polynomial x^7+x^3+1 with initial value 0.
  - 48-bit frames: computed over frame bits [47:8], compared with [7:1].
  - R2: computed over payload bits [127:8] only; the header is excluded.
  - R3: no CRC check; the field must read 7'h7F or frame_err is set.
- CHECK evaluates the following; errors are ORed:
  - frame_err: transmission bit ≠ 0, or end bit ≠ 1.
  - crc_err: CRC mismatch (skipped for R3).
  - index_err (R1/R6/R7): frame[45:40] ≠ exp_index.
  - index_err (R2/R3): header index ≠ 6'h3F.
- When no error flag is set, enables pulse by type:
  - R1, R7: stat_en; stat_data={26'b0, index, content[31:0]}.
  - R6: rca_en with rca_data=content[31:16]; stat_en with stat_data={26'b0, index, 16'b0, content[15:0]}.
  - R3: ocr_en; ocr_data=content[31:0]; stat_en with index field 6'h3F.
  - R2: cid_en or csd_en per r2_is_csd; r2_data={payload[127:1], 1'b1}.
- When any error is set: no enables; data buses are still updated.
- Data buses hold their value until the next CHECK.
- start while busy=1 is ignored. There is no abort input; reset is the only abort.

## Timing
- Reset values: busy, done, every flag, every enable = 0; r2_data, ocr_data, rca_data, stat_data = 0; state IDLE.
- start accepted at edge T: busy=1 after T; the first cmd_in sample at edge T+1.
- Start bit sampled at edge S: the end bit is sampled at edge S+L−1. done and enables are high for exactly one cycle, starting after edge S+L. busy falls in the same cycle done rises.
- Timeout: with no start bit, done and timeout_err rise after edge T+NCR_MAX+1.
- A start bit on the very last allowed sample (count NCR_MAX−1) is accepted, not a timeout.
- Back-to-back: a start in the same cycle as done is accepted.
- Reset low mid-RECV: next edge gives IDLE and all outputs 0; partial frame discarded; no done.

## Test plan
- R1 test, exp_index=17: frame index 17, status 32'h00000900, correct CRC7, end 1 → done after 48 bits; stat_en=1; stat_data=64'h0000_0011_0000_0900; all flags 0.
- R6 test, exp_index=3: content 32'hAAAA0520, good CRC → rca_en and stat_en together; rca_data=16'hAAAA; stat_data[15:0]=16'h0520.
- R2 test, r2_is_csd=1: payload 128'h400E00325B5900003B377F800A404000 with correct CRC in [7:1] → csd_en only; r2_data equals the payload with bit0=1.
- R3 test: OCR 32'hC0FF8000, CRC field 7'h7F → ocr_en; ocr_data=32'hC0FF8000. Repeat with a flipped content bit: still accepted, since no CRC check applies.
- Error cases on an R1 frame:
  - one CRC bit flipped → crc_err=1, no enables.
  - index 18 against exp_index=17 → index_err=1.
  - end bit 0 → frame_err=1.
- Timeout and reset:
  - cmd_in held 1 after start → timeout_err and done exactly NCR_MAX+1 edges after start; busy drops.
  - reset asserted at bit 20 of a frame → all outputs 0, no done.
  - a fresh start afterwards receives a good R1 normally.
